// File: rtl/vga_timing_gen_if.sv
// Video timing bundle between the raster generator, the grid-to-pixel translator and the DAC pins.
interface vga_timing_gen_if;
    logic [7:0] rgb_in;
    logic       px_tick;
    logic       px_en;
    logic       frame_start;
    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       hsync;
    logic       vsync;
    logic [7:0] rgb_out;

    modport master (
        input  rgb_in,
        output px_tick, px_en, frame_start, h_count, v_count, hsync, vsync, rgb_out
    );

    modport slave (
        output rgb_in,
        input  px_tick, px_en, frame_start, h_count, v_count, hsync, vsync, rgb_out
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing from a 2x clock; syncs and blank gate delayed to match translator latency.
// state | meaning
// H_ACT | visible columns          V_ACT | visible lines
// H_FP  | horizontal front porch   V_FP  | vertical front porch
// H_SY  | hsync pulse              V_SY  | vsync pulse
// H_BP  | horizontal back porch    V_BP  | vertical back porch
module vga_timing_gen #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int SYNC_ACTIVE = 0,
    parameter int PIPE_DELAY  = 2
) (
    input logic              clk,
    input logic              reset,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FP_START = 10'(H_VISIBLE);
    localparam logic [9:0] H_SY_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_BP_START = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FP_START = 10'(V_VISIBLE);
    localparam logic [9:0] V_SY_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_BP_START = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic       SYNC_ON    = (SYNC_ACTIVE != 0);
    localparam int         EN_W       = (PIPE_DELAY > 0) ? PIPE_DELAY : 1;

    typedef enum logic [1:0] {H_ACT, H_FP, H_SY, H_BP} h_state_t;
    typedef enum logic [1:0] {V_ACT, V_FP, V_SY, V_BP} v_state_t;

    h_state_t h_state, h_state_nxt;
    v_state_t v_state, v_state_nxt;

    logic                  tog;
    logic                  px_tick;
    logic [9:0]            h_count, h_nxt;
    logic [9:0]            v_count, v_nxt;
    logic                  frame_start, fs_nxt;
    logic                  en_nxt, hs_nxt, vs_nxt;
    logic [EN_W-1:0]       en_pipe;
    logic [PIPE_DELAY:0]   en_pipe_nxt;
    logic [PIPE_DELAY:0]   hs_pipe, vs_pipe;
    logic [7:0]            rgb_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tog     <= 1'b0;
            px_tick <= 1'b0;
        end else begin
            tog     <= ~tog;
            px_tick <= tog;
        end
    end

    // Reset parks the counters on the last position so the first tick enters (0,0).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_state <= H_BP;
            v_state <= V_BP;
        end else if (tog) begin
            h_state <= h_state_nxt;
            v_state <= v_state_nxt;
        end
    end

    always_comb begin
        h_nxt       = h_count;
        v_nxt       = v_count;
        h_state_nxt = h_state;
        v_state_nxt = v_state;
        if (tog) begin
            if (h_count == H_LAST) begin
                h_nxt = '0;
                v_nxt = (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
            end else begin
                h_nxt = h_count + 10'd1;
            end
            case (h_state)
                H_ACT:   if (h_nxt == H_FP_START) h_state_nxt = H_FP;
                H_FP:    if (h_nxt == H_SY_START) h_state_nxt = H_SY;
                H_SY:    if (h_nxt == H_BP_START) h_state_nxt = H_BP;
                H_BP:    if (h_nxt == 10'd0)      h_state_nxt = H_ACT;
                default: h_state_nxt = H_ACT;
            endcase
            case (v_state)
                V_ACT:   if (v_nxt == V_FP_START) v_state_nxt = V_FP;
                V_FP:    if (v_nxt == V_SY_START) v_state_nxt = V_SY;
                V_SY:    if (v_nxt == V_BP_START) v_state_nxt = V_BP;
                V_BP:    if (v_nxt == 10'd0)      v_state_nxt = V_ACT;
                default: v_state_nxt = V_ACT;
            endcase
        end
    end

    always_comb begin
        en_nxt = (h_state_nxt == H_ACT) && (v_state_nxt == V_ACT);
        hs_nxt = (h_state_nxt == H_SY);
        vs_nxt = (v_state_nxt == V_SY);
        fs_nxt = (h_nxt == 10'd0) && (v_nxt == 10'd0);
        en_pipe_nxt    = '0;
        en_pipe_nxt[0] = en_nxt;
        for (int i = 1; i <= PIPE_DELAY; i++) begin
            en_pipe_nxt[i] = en_pipe[i-1];
        end
    end

    // Stage 0 of each pipe is the undelayed value; stage PIPE_DELAY feeds the pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_count     <= H_LAST;
            v_count     <= V_LAST;
            frame_start <= 1'b0;
            en_pipe     <= '0;
            hs_pipe     <= '0;
            vs_pipe     <= '0;
            rgb_out     <= '0;
        end else if (tog) begin
            h_count     <= h_nxt;
            v_count     <= v_nxt;
            frame_start <= fs_nxt;
            en_pipe     <= en_pipe_nxt[EN_W-1:0];
            hs_pipe[0]  <= hs_nxt;
            vs_pipe[0]  <= vs_nxt;
            for (int i = 1; i <= PIPE_DELAY; i++) begin
                hs_pipe[i] <= hs_pipe[i-1];
                vs_pipe[i] <= vs_pipe[i-1];
            end
            rgb_out     <= en_pipe_nxt[PIPE_DELAY] ? bus.rgb_in : 8'h00;
        end
    end

    assign bus.px_tick     = px_tick;
    assign bus.px_en       = en_pipe[0];
    assign bus.frame_start = frame_start;
    assign bus.h_count     = h_count;
    assign bus.v_count     = v_count;
    assign bus.hsync       = hs_pipe[PIPE_DELAY] ? SYNC_ON : ~SYNC_ON;
    assign bus.vsync       = vs_pipe[PIPE_DELAY] ? SYNC_ON : ~SYNC_ON;
    assign bus.rgb_out     = rgb_out;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: full-size generator for line timing, reduced-geometry generator (delay 0, active-high sync) for frame timing.
module tb_vga_timing_gen;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if ifa();
    vga_timing_gen_if ifb();

    vga_timing_gen dut_a (.clk(clk), .reset(reset), .bus(ifa));

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .SYNC_ACTIVE(1), .PIPE_DELAY(0)
    ) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    typedef struct {
        int         k;
        logic [9:0] h;
        logic [9:0] v;
        logic       en;
        logic       hs;
        logic       vs;
        logic       fs;
        logic [7:0] rgb;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ifa.px_tick !== 1'b1 && n < 4);
        if (ifa.px_tick !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_timeout: px_tick not seen within %0d clks", n);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_a_tick"},  32'(ifa.px_tick),     32'd0);
        chk({tag, "_a_h"},     32'(ifa.h_count),     32'd799);
        chk({tag, "_a_v"},     32'(ifa.v_count),     32'd524);
        chk({tag, "_a_en"},    32'(ifa.px_en),       32'd0);
        chk({tag, "_a_fs"},    32'(ifa.frame_start), 32'd0);
        chk({tag, "_a_rgb"},   32'(ifa.rgb_out),     32'd0);
        chk({tag, "_a_hs"},    32'(ifa.hsync),       32'd1);
        chk({tag, "_a_vs"},    32'(ifa.vsync),       32'd1);
        chk({tag, "_b_h"},     32'(ifb.h_count),     32'd15);
        chk({tag, "_b_v"},     32'(ifb.v_count),     32'd8);
        chk({tag, "_b_hs"},    32'(ifb.hsync),       32'd0);
        chk({tag, "_b_vs"},    32'(ifb.vsync),       32'd0);
        chk({tag, "_b_rgb"},   32'(ifb.rgb_out),     32'd0);
    endtask

    task automatic release_and_first_tick(input string tag);
        int n = 0;
        reset = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (ifa.px_tick !== 1'b1 && n < 6);
        chk({tag, "_first_tick_latency"}, 32'(n), 32'd2);
        chk({tag, "_first_a_pos"}, {12'd0, ifa.h_count, ifa.v_count}, 32'd0);
        chk({tag, "_first_a_en_fs"}, {30'd0, ifa.px_en, ifa.frame_start}, 32'd3);
        chk({tag, "_first_b_pos"}, {12'd0, ifb.h_count, ifb.v_count}, 32'd0);
        chk({tag, "_first_b_en_fs"}, {30'd0, ifb.px_en, ifb.frame_start}, 32'd3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ti = 0;
        int a_en_high = 0, a_hs_act = 0, a_en_fall = 0;
        int b_en_fall = 0, b_fs = 0, b_vs_act = 0;
        logic a_en_prev = 1'b0, b_en_prev = 1'b0;

        //          k    h    v  en hs vs fs rgb
        tbl[0]  = '{0,   0,   0, 1, 1, 1, 1, 8'h00};
        tbl[1]  = '{1,   1,   0, 1, 1, 1, 0, 8'h00};
        tbl[2]  = '{2,   2,   0, 1, 1, 1, 0, 8'hA5};
        tbl[3]  = '{639, 639, 0, 1, 1, 1, 0, 8'hA5};
        tbl[4]  = '{640, 640, 0, 0, 1, 1, 0, 8'hA5};
        tbl[5]  = '{641, 641, 0, 0, 1, 1, 0, 8'hA5};
        tbl[6]  = '{642, 642, 0, 0, 1, 1, 0, 8'h00};
        tbl[7]  = '{657, 657, 0, 0, 1, 1, 0, 8'h00};
        tbl[8]  = '{658, 658, 0, 0, 0, 1, 0, 8'h00};
        tbl[9]  = '{753, 753, 0, 0, 0, 1, 0, 8'h00};
        tbl[10] = '{754, 754, 0, 0, 1, 1, 0, 8'h00};
        tbl[11] = '{799, 799, 0, 0, 1, 1, 0, 8'h00};
        tbl[12] = '{800, 0,   1, 1, 1, 1, 0, 8'h00};
        tbl[13] = '{802, 2,   1, 1, 1, 1, 0, 8'hA5};

        ifa.rgb_in = 8'hA5;
        ifb.rgb_in = 8'hA5;
        reset      = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");
        release_and_first_tick("por");

        for (int k = 0; k <= 1100; k++) begin
            if (ti < 14 && k == tbl[ti].k) begin
                chk($sformatf("a_vec_k%0d", k),
                    {7'd0, tbl[ti].h, tbl[ti].v, tbl[ti].en, tbl[ti].hs, tbl[ti].vs},
                    {7'd0, ifa.h_count, ifa.v_count, ifa.px_en, ifa.hsync, ifa.vsync});
                chk($sformatf("a_vec_fs_rgb_k%0d", k), {23'd0, tbl[ti].fs, tbl[ti].rgb},
                    {23'd0, ifa.frame_start, ifa.rgb_out});
                ti++;
            end
            if (k < 800) begin
                if (ifa.px_en) a_en_high++;
                if (ifa.hsync == 1'b0) a_hs_act++;
                if (a_en_prev && !ifa.px_en) a_en_fall++;
                a_en_prev = ifa.px_en;
            end
            if (k < 288) begin
                int hb, vb;
                logic eb;
                hb = k % 16;
                vb = (k / 16) % 9;
                eb = (hb < 8) && (vb < 4);
                chk($sformatf("b_tick_k%0d", k),
                    {10'(hb), 10'(vb), eb, logic'(hb >= 10 && hb <= 12), logic'(vb >= 5 && vb <= 6),
                     logic'(hb == 0 && vb == 0), eb ? 8'hA5 : 8'h00},
                    {ifb.h_count, ifb.v_count, ifb.px_en, ifb.hsync, ifb.vsync, ifb.frame_start, ifb.rgb_out});
                if (b_en_prev && !ifb.px_en) b_en_fall++;
                b_en_prev = ifb.px_en;
                if (ifb.frame_start) b_fs++;
                if (ifb.vsync) b_vs_act++;
            end
            if (k == 5) begin
                @(negedge clk);
                chk("hold_between_ticks", {21'd0, ifa.px_tick, ifa.h_count, ifa.px_en},
                    {21'd0, 1'b0, 10'd5, 1'b1});
            end
            if (k < 1100) wait_tick();
        end

        chk("a_line_en_ticks",   32'(a_en_high), 32'd640);
        chk("a_line_hs_ticks",   32'(a_hs_act),  32'd96);
        chk("a_line_en_falls",   32'(a_en_fall), 32'd1);
        chk("b_2frame_en_falls", 32'(b_en_fall), 32'd8);
        chk("b_2frame_fs",       32'(b_fs),      32'd2);
        chk("b_2frame_vs_ticks", 32'(b_vs_act),  32'd64);

        chk("a_pre_reset_pos", {12'd0, ifa.h_count, ifa.v_count}, {12'd0, 10'd300, 10'd1});
        reset = 1'b0;
        #1;
        check_reset("mid");
        repeat (3) @(negedge clk);
        release_and_first_tick("mid");
        wait_tick();
        chk("mid_second_tick_a", {20'd0, ifa.h_count, ifa.px_en, ifa.frame_start}, {20'd0, 10'd1, 1'b1, 1'b0});
        chk("mid_second_tick_b", {20'd0, ifb.h_count, ifb.px_en, ifb.frame_start}, {20'd0, 10'd1, 1'b1, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
